// File: rtl/fruit_motion.sv
// Fruit sprite motion for a slicing game: timed launch, ballistic flight with
// wall bounce, slice/miss scoring. All motion advances on frames of the VGA vertical sync.
module fruit_motion #(
    parameter logic [7:0] SLICE_KEY    = 8'h2C,
    parameter int         FRUIT_SIZE   = 16,
    parameter int         V0           = 12,
    parameter int         GRAVITY      = 1,
    parameter int         SPAWN_FRAMES = 30,
    parameter int         SPLAT_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       run,
    input  logic [7:0] keycode,
    output logic [9:0] FruitX,
    output logic [9:0] FruitY,
    output logic [9:0] FruitS,
    output logic       fruit_active,
    output logic       fruit_sliced,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score
);

    typedef enum logic [1:0] {IDLE, WAIT, FLY, SPLAT} state_t;

    localparam int CNT_MAX = (SPAWN_FRAMES > SPLAT_FRAMES) ? SPAWN_FRAMES : SPLAT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SPAWN_LAST = CNT_W'(SPAWN_FRAMES - 1);
    localparam logic [CNT_W-1:0]   SPLAT_LAST = CNT_W'(SPLAT_FRAMES - 1);
    localparam logic signed [10:0] Y_FLOOR    = 11'(480 - FRUIT_SIZE);
    localparam logic signed [10:0] X_MAX      = 11'(640 - FRUIT_SIZE);
    localparam logic signed [10:0] VY_LAUNCH  = 11'(-V0);
    localparam logic signed [10:0] GRAV       = 11'(GRAVITY);

    state_t state, next_state;

    logic             frame_sync1, frame_sync2, frame_prev, frame_tick;
    logic [7:0]       key_q, key_prev;
    logic             slice_evt;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] frame_cnt;

    logic signed [10:0] x, y, vx, vy;
    logic signed [10:0] nx, ny, nvx, nvy;

    logic launch, fly_step, do_slice, do_miss, cnt_clr, cnt_inc;

    // Input conditioning: vsync crosses into Clk through two flops; a tick marks the
    // end of the active-low sync pulse. The key edge detector fires once per press.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_sync1 <= 1'b0;
            frame_sync2 <= 1'b0;
            frame_prev  <= 1'b0;
            key_q       <= '0;
            key_prev    <= '0;
            lfsr        <= 16'hACE1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, so the
            // synchronizer chain and LFSR shift behave as real registers regardless of order.
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_prev  <= frame_sync2;
            key_q       <= keycode;
            key_prev    <= key_q;
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign frame_tick = frame_sync2 & ~frame_prev;
    assign slice_evt  = (key_q == SLICE_KEY) && (key_prev != SLICE_KEY);

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so that no path
        // through the case statement leaves a signal unassigned and infers a latch.
        next_state = state;
        launch     = 1'b0;
        fly_step   = 1'b0;
        do_slice   = 1'b0;
        do_miss    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        nx  = x + vx;
        ny  = y + vy;
        nvx = vx;
        nvy = vy + GRAV;
        if (nx < 11'sd0) begin
            nx  = '0;
            nvx = -vx;
        end else if (nx > X_MAX) begin
            nx  = X_MAX;
            nvx = -vx;
        end

        case (state)
            IDLE: begin
                if (run) next_state = WAIT;
            end
            WAIT: begin
                if (frame_tick) begin
                    if (frame_cnt == SPAWN_LAST) begin
                        launch     = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = FLY;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            FLY: begin
                // A slice freezes the fruit where it is, even on a frame that would miss.
                if (slice_evt) begin
                    do_slice   = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = SPLAT;
                end else if (frame_tick) begin
                    fly_step = 1'b1;
                    if ((ny > Y_FLOOR) && (vy > 11'sd0)) begin
                        do_miss    = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            SPLAT: begin
                if (frame_tick) begin
                    if (frame_cnt == SPLAT_LAST) begin
                        cnt_clr    = 1'b1;
                        next_state = WAIT;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        if (!run) begin
            next_state = IDLE;
            launch     = 1'b0;
            fly_step   = 1'b0;
            do_slice   = 1'b0;
            do_miss    = 1'b0;
            cnt_inc    = 1'b0;
            cnt_clr    = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
            x         <= '0;
            y         <= '0;
            vx        <= '0;
            vy        <= '0;
            score     <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
        end else begin
            hit  <= do_slice;
            miss <= do_miss;

            if (cnt_clr)      frame_cnt <= '0;
            else if (cnt_inc) frame_cnt <= frame_cnt + CNT_W'(1);

            if (do_slice && (score != 8'hFF)) score <= score + 8'd1;

            // lfsr[8:0] never exceeds 511, so the 576-wide launch band needs no wrap.
            if (launch) begin
                x  <= {2'b00, lfsr[8:0]} + 11'd32;
                y  <= Y_FLOOR;
                vy <= VY_LAUNCH;
                vx <= $signed({9'b0, lfsr[1:0]}) - 11'sd2;
            end else if (fly_step) begin
                x  <= nx;
                y  <= ny;
                vx <= nvx;
                vy <= nvy;
            end
        end
    end

    assign FruitX       = x[9:0];
    assign FruitY       = y[9:0];
    assign FruitS       = 10'(FRUIT_SIZE);
    assign fruit_active = (state == FLY);
    assign fruit_sliced = (state == SPLAT);

endmodule

// File: tb/tb_fruit_motion.sv
// Directed bench for fruit_motion: launch timing, ballistic path, wall bounce,
// slice/miss priority, splat hold, score and reset behaviour.
module tb_fruit_motion;

    localparam logic [7:0] SLICE_KEY = 8'h2C;

    logic       Clk = 1'b0;
    logic       Reset_n, frame_clk, run;
    logic [7:0] keycode;
    logic [9:0] FruitX, FruitY, FruitS;
    logic       fruit_active, fruit_sliced, hit, miss;
    logic [7:0] score;

    always #10 Clk = ~Clk;

    fruit_motion dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .run          (run),
        .keycode      (keycode),
        .FruitX       (FruitX),
        .FruitY       (FruitY),
        .FruitS       (FruitS),
        .fruit_active (fruit_active),
        .fruit_sliced (fruit_sliced),
        .hit          (hit),
        .miss         (miss),
        .score        (score)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitors, sampled away from the active edge.
    int hit_cnt  = 0;
    int miss_cnt = 0;
    int both_cnt = 0;
    always @(negedge Clk) begin
        if (hit)         hit_cnt++;
        if (miss)        miss_cnt++;
        if (hit && miss) both_cnt++;
    end

    // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded on reset, one step per clock.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge Clk) begin
        if (!Reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= lfsr_next(m_lfsr);
    end

    logic [15:0] tick_lfsr;
    int mx, my, mvx, mvy;
    int exp_score = 0;
    bit saw_zero;

    // One vsync pulse; key optionally pressed so its edge lands on the tick cycle.
    task automatic frame_tick(input bit press);
        frame_clk = 1'b1;
        @(negedge Clk);
        if (press) keycode = SLICE_KEY;
        @(negedge Clk);
        tick_lfsr = m_lfsr;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic model_step(output bit missed);
        int nx, ny;
        nx = mx + mvx;
        ny = my + mvy;
        missed = (ny > 464) && (mvy > 0);
        mvy = mvy + 1;
        if (nx < 0) begin
            nx  = 0;
            mvx = -mvx;
        end else if (nx > 624) begin
            nx  = 624;
            mvx = -mvx;
        end
        mx = nx;
        my = ny;
    endtask

    task automatic fly(input int n, input string tag);
        bit missed;
        for (int i = 0; i < n; i++) begin
            frame_tick(1'b0);
            model_step(missed);
            check({tag, "_x"}, int'(FruitX), mx);
            check({tag, "_y"}, int'(FruitY), my);
            check({tag, "_active"}, int'(fruit_active), missed ? 0 : 1);
            if (FruitX == 10'd0) saw_zero = 1'b1;
        end
    endtask

    // 29 idle ticks, optional wait for a low-x leftward launch, then the launching tick.
    task automatic launch_fruit(input bit steer, input string tag);
        int budget;
        for (int i = 0; i < 29; i++) frame_tick(1'b0);
        check({tag, "_pre_active"}, int'(fruit_active), 0);
        if (steer) begin
            logic [15:0] p;
            budget = 20000;
            p = lfsr_next(lfsr_next(m_lfsr));
            while (!((p[1:0] == 2'd0) && (p[8:0] < 9'd20)) && budget > 0) begin
                @(negedge Clk);
                budget--;
                p = lfsr_next(lfsr_next(m_lfsr));
            end
            check({tag, "_steer_budget"}, int'(budget > 0), 1);
        end
        frame_tick(1'b0);
        mx  = 32 + (int'(tick_lfsr[8:0]) % 576);
        my  = 464;
        mvy = -12;
        mvx = int'(tick_lfsr[1:0]) - 2;
        check({tag, "_launch_x"}, int'(FruitX), mx);
        check({tag, "_launch_y"}, int'(FruitY), 464);
        check({tag, "_launch_active"}, int'(fruit_active), 1);
    endtask

    task automatic splat_hold(input string tag);
        for (int i = 0; i < 7; i++) begin
            frame_tick(1'b0);
            check({tag, "_frozen_x"}, int'(FruitX), mx);
            check({tag, "_frozen_y"}, int'(FruitY), my);
            check({tag, "_sliced"}, int'(fruit_sliced), 1);
        end
        frame_tick(1'b0);
        check({tag, "_sliced_end"}, int'(fruit_sliced), 0);
        check({tag, "_active_end"}, int'(fruit_active), 0);
    endtask

    initial begin
        Reset_n   = 1'b0;
        run       = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        repeat (3) @(negedge Clk);

        check("rst_x", int'(FruitX), 0);
        check("rst_y", int'(FruitY), 0);
        check("rst_size", int'(FruitS), 16);
        check("rst_active", int'(fruit_active), 0);
        check("rst_sliced", int'(fruit_sliced), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_score", int'(score), 0);

        Reset_n = 1'b1;
        run     = 1'b1;

        // Full flight: apex after 12 frames, miss on the 26th.
        launch_fruit(1'b0, "f1");
        fly(12, "f1_rise");
        check("f1_apex_y", int'(FruitY), 386);
        fly(1, "f1_apex");
        check("f1_apex_hold_y", int'(FruitY), 386);
        fly(12, "f1_fall");
        check("f1_no_early_miss", miss_cnt, 0);
        fly(1, "f1_miss");
        check("f1_miss_cnt", miss_cnt, 1);
        check("f1_miss_y", int'(FruitY), 477);
        check("f1_miss_active", int'(fruit_active), 0);
        check("f1_score", int'(score), 0);

        // Leftward launch near the wall: clamp at 0 and reverse.
        saw_zero = 1'b0;
        launch_fruit(1'b1, "f2");
        check("f2_vx", mvx, -2);
        fly(26, "f2");
        check("f2_wall_zero", int'(saw_zero), 1);
        check("f2_miss_cnt", miss_cnt, 2);
        check("f2_hit_cnt", hit_cnt, 0);

        // Slice on flight frame 5, key held ~100 cycles.
        launch_fruit(1'b0, "f3");
        fly(4, "f3_pre");
        frame_tick(1'b1);
        exp_score++;
        check("f3_hit_cnt", hit_cnt, 1);
        check("f3_score", int'(score), exp_score);
        check("f3_sliced", int'(fruit_sliced), 1);
        check("f3_active", int'(fruit_active), 0);
        check("f3_x", int'(FruitX), mx);
        check("f3_y", int'(FruitY), my);
        splat_hold("f3");
        repeat (47) @(negedge Clk);
        keycode = 8'h00;
        check("f3_hold_hit_cnt", hit_cnt, 1);
        check("f3_hold_score", int'(score), exp_score);

        // Slice lands on the frame that would have missed.
        launch_fruit(1'b0, "f4");
        fly(25, "f4_pre");
        frame_tick(1'b1);
        keycode = 8'h00;
        exp_score++;
        check("f4_hit_cnt", hit_cnt, 2);
        check("f4_miss_cnt", miss_cnt, 2);
        check("f4_score", int'(score), exp_score);
        check("f4_y", int'(FruitY), 464);
        splat_hold("f4");

        // Build the score up to 7 with immediate slices.
        for (int s = 0; s < 5; s++) begin
            launch_fruit(1'b0, "fs");
            frame_tick(1'b1);
            keycode = 8'h00;
            exp_score++;
            check("fs_score", int'(score), exp_score);
            splat_hold("fs");
        end
        check("fs_score7", int'(score), 7);
        check("fs_hit_cnt", hit_cnt, 7);

        // Reset mid-flight, with run high and a fresh key edge in the same cycle.
        launch_fruit(1'b0, "f5");
        fly(3, "f5_pre");
        keycode = SLICE_KEY;
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        check("mid_rst_x", int'(FruitX), 0);
        check("mid_rst_y", int'(FruitY), 0);
        check("mid_rst_active", int'(fruit_active), 0);
        check("mid_rst_sliced", int'(fruit_sliced), 0);
        check("mid_rst_hit", int'(hit), 0);
        check("mid_rst_miss", int'(miss), 0);
        check("mid_rst_score", int'(score), 0);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        check("mid_rst_hit_cnt", hit_cnt, 7);
        Reset_n = 1'b1;

        launch_fruit(1'b0, "f6");
        fly(2, "f6");

        // Dropping run abandons the flight; relaunch needs a full wait again.
        run = 1'b0;
        repeat (2) @(negedge Clk);
        check("run_off_active", int'(fruit_active), 0);
        run = 1'b1;
        launch_fruit(1'b0, "f7");

        check("hit_miss_overlap", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
